// File: rtl/acc_dump_sched.sv
// Buffers 256-bit acc trigger records during a scan window and serializes each
// record as four 64-bit words on a valid/ready stream, with per-scan counters.
module acc_dump_sched #(
  parameter real         TCQ   = 0.1,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         pmt_scan_en_i,
  input  logic         rec_en_i,
  input  logic [255:0] rec_data_i,
  output logic         dout_valid_o,
  input  logic         dout_ready_i,
  output logic [63:0]  dout_data_o,
  output logic         dout_last_o,
  output logic [31:0]  rec_out_num_o,
  output logic [31:0]  rec_drop_num_o,
  output logic         busy_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // TCQ is kept for source compatibility only; registers carry no modelled delay.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TCQ < 0.0) begin : g_bad_param
    $error("acc_dump_sched: DEPTH must be a power of two >= 2 and TCQ >= 0");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t            state, state_nxt;
  logic [255:0]      mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count, count_nxt;
  logic [3:0][63:0]  out_reg;
  logic [1:0]        idx;
  logic              scan_q;
  logic              wr_req, wr_en, drop, pop, hs, rec_done, scan_rise;

  assign wr_req    = rec_en_i && pmt_scan_en_i;
  assign wr_en     = wr_req && (count < DEPTH_C);
  assign drop      = wr_req && (count == DEPTH_C);
  assign pop       = (state == LOAD);
  assign hs        = (state == SEND) && dout_ready_i;
  assign rec_done  = hs && (idx == 2'd3);
  assign scan_rise = pmt_scan_en_i && !scan_q;

  always_comb begin
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    dout_valid_o = 1'b0;
    dout_data_o  = '0;
    dout_last_o  = 1'b0;
    case (state)
      IDLE: if (count != '0) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: begin
        dout_valid_o = 1'b1;
        dout_data_o  = out_reg[idx];
        dout_last_o  = (idx == 2'd3);
        // Decide on post-update occupancy so a write landing this cycle is seen.
        if (rec_done) state_nxt = (count_nxt != '0) ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (count != '0) || (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr] <= rec_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      out_reg <= '0;
      idx     <= '0;
      scan_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      scan_q <= pmt_scan_en_i;
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr    <= rptr + AW'(1);
        out_reg <= mem[rptr];
        idx     <= '0;
      end else if (hs) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Scan-rise clear takes priority but still counts an event in that same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rec_out_num_o  <= '0;
      rec_drop_num_o <= '0;
    end else begin
      if (scan_rise)
        rec_out_num_o <= {31'd0, rec_done};
      else if (rec_done && rec_out_num_o != '1)
        rec_out_num_o <= rec_out_num_o + 32'd1;

      if (scan_rise)
        rec_drop_num_o <= {31'd0, drop};
      else if (drop && rec_drop_num_o != '1)
        rec_drop_num_o <= rec_drop_num_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_acc_dump_sched.sv
// Self-checking bench for acc_dump_sched: table of single-record vectors plus
// hand-written multi-cycle sequences, with a word scoreboard on the output stream.
module tb_acc_dump_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         scan;
  logic         rec_en;
  logic [255:0] rec_data;
  logic         dout_valid;
  logic         dout_ready;
  logic [63:0]  dout_data;
  logic         dout_last;
  logic [31:0]  out_num;
  logic [31:0]  drop_num;
  logic         busy;

  acc_dump_sched #(.DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pmt_scan_en_i  (scan),
    .rec_en_i       (rec_en),
    .rec_data_i     (rec_data),
    .dout_valid_o   (dout_valid),
    .dout_ready_i   (dout_ready),
    .dout_data_o    (dout_data),
    .dout_last_o    (dout_last),
    .rec_out_num_o  (out_num),
    .rec_drop_num_o (drop_num),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    bit           scan;
    logic [31:0]  exp_out;
  } vec_t;

  int           n_vec = 0;
  int           n_err = 0;
  logic [64:0]  sb[$];
  logic [64:0]  exp_e;
  logic         prev_stall = 1'b0;
  logic [63:0]  prev_data;
  logic         prev_last;

  function automatic logic [255:0] mk(input logic [63:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pop on handshake and stall-stability check.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", dout_valid, 1);
        check("hold_data", dout_data, prev_data);
        check("hold_last", dout_last, prev_last);
      end
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected no word (t=%0t)", dout_data, $time);
        end else begin
          exp_e = sb.pop_front();
          check("sb_data", dout_data, exp_e[63:0]);
          check("sb_last", dout_last, exp_e[64]);
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_data  = dout_data;
      prev_last  = dout_last;
    end
  end

  task automatic drive_rec(input logic [255:0] d, input bit s, input bit push);
    @(posedge clk); #1;
    rec_en   = 1'b1;
    rec_data = d;
    scan     = s;
    if (push)
      for (int k = 0; k < 4; k++) sb.push_back({k == 3, d[64*k +: 64]});
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    rec_en   = 1'b0;
    rec_data = '0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < max);
    check({name, "_drain"}, (busy || sb.size() != 0) ? 64'd1 : 64'd0, 0);
  endtask

  task automatic wait_word(input logic [63:0] w, input int max, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dout_valid && dout_data == w) && n < max);
    check({name, "_seen"}, (dout_valid && dout_data == w) ? 64'd1 : 64'd0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[6];
    logic [255:0] d;
    int           n;
    bit           seen;

    vt[0] = '{mk(64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0, 64'hffffffffffffffff), 1'b1, 32'd2};
    vt[1] = '{mk(64'haaaaaaaaaaaaaaaa, 64'h5555555555555555, 64'haaaaaaaaaaaaaaaa, 64'h5555555555555555), 1'b1, 32'd3};
    vt[2] = '{mk(64'hdead, 64'hbeef, 64'hcafe, 64'hf00d), 1'b0, 32'd3};
    vt[3] = '{mk(64'h1, 64'h2, 64'h4, 64'h8), 1'b1, 32'd1};
    vt[4] = '{mk(64'h8000000000000000, 64'h1, 64'h7fffffffffffffff, 64'h0), 1'b1, 32'd2};
    vt[5] = '{'1, 1'b1, 32'd3};

    rst = 1'b1; scan = 1'b0; rec_en = 1'b0; rec_data = '0; dout_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", dout_valid, 0);
    check("rst_last", dout_last, 0);
    check("rst_data", dout_data, 0);
    check("rst_out_num", out_num, 0);
    check("rst_drop_num", drop_num, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 scan = 1'b1;

    // Single record: 3-cycle latency, words on consecutive cycles
    drive_rec(mk(64'd1, 64'd2, 64'd3, 64'd4), 1'b1, 1'b1);
    idle_in();
    @(negedge clk); check("lat_n1_valid", dout_valid, 0);
    @(negedge clk); check("lat_n2_valid", dout_valid, 0);
    @(negedge clk); check("lat_n3_valid", dout_valid, 1);
    check("lat_w0", dout_data, 64'd1); check("lat_w0_last", dout_last, 0);
    @(negedge clk); check("lat_w1", dout_data, 64'd2); check("lat_w1_last", dout_last, 0);
    @(negedge clk); check("lat_w2", dout_data, 64'd3); check("lat_w2_last", dout_last, 0);
    @(negedge clk); check("lat_w3", dout_data, 64'd4); check("lat_w3_last", dout_last, 1);
    wait_idle(20, "lat");
    check("lat_out_num", out_num, 1);

    // Table vectors, one record each (scan-low entry ignored, next one clears on rise)
    for (int i = 0; i < 6; i++) begin
      drive_rec(vt[i].data, vt[i].scan, vt[i].scan);
      idle_in();
      wait_idle(60, "vec");
      check("vec_out_num", out_num, vt[i].exp_out);
      check("vec_drop_num", drop_num, 0);
    end

    // Back-pressure during word 2
    drive_rec(mk(64'h11, 64'h22, 64'h33, 64'h44), 1'b1, 1'b1);
    idle_in();
    wait_word(64'h11, 20, "stall");
    @(posedge clk); #1 dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", dout_valid, 1);
      check("stall_data", dout_data, 64'h22);
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    wait_idle(20, "stall");
    check("stall_out_num", out_num, 4);

    // Scan re-arm clears counters
    @(posedge clk); #1 scan = 1'b0;
    @(posedge clk); #1 scan = 1'b1;
    repeat (2) @(negedge clk);
    check("rearm_out_num", out_num, 0);

    // Overflow: 6 records with sink stalled, one dropped, then timed drain
    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = mk(64'h100 + 64'(i), 64'h200 + 64'(i), 64'h300 + 64'(i), 64'h400 + 64'(i));
      drive_rec(d, 1'b1, i < 5);
    end
    idle_in();
    @(negedge clk);
    check("ovf_drop_num", drop_num, 1);
    check("ovf_valid", dout_valid, 1);
    check("ovf_head", dout_data, 64'h100);
    check("ovf_busy", busy, 1);
    @(posedge clk); #1 dout_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    check("ovf_drain_cycles", 64'(n), 25);
    wait_idle(5, "ovf");
    check("ovf_out_num", out_num, 5);
    check("ovf_drop_keep", drop_num, 1);

    // Strobe with scan low is ignored; falling edge does not clear
    @(posedge clk); #1 scan = 1'b0;
    drive_rec(mk(64'h9, 64'h9, 64'h9, 64'h9), 1'b0, 1'b0);
    idle_in();
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dout_valid || busy) seen = 1'b1;
    end
    check("scanlo_activity", seen, 0);
    check("scanlo_out_num", out_num, 5);
    check("scanlo_drop_num", drop_num, 1);

    // Scan falls mid-drain, drain completes and counts; rise clears
    @(posedge clk); #1 scan = 1'b1;
    repeat (2) @(negedge clk);
    check("rise_clr_out", out_num, 0);
    check("rise_clr_drop", drop_num, 0);
    drive_rec(mk(64'ha0, 64'ha1, 64'ha2, 64'ha3), 1'b1, 1'b1);
    drive_rec(mk(64'hb0, 64'hb1, 64'hb2, 64'hb3), 1'b1, 1'b1);
    idle_in();
    wait_word(64'ha1, 20, "middrain");
    @(posedge clk); #1 scan = 1'b0;
    wait_idle(40, "middrain");
    check("middrain_out_num", out_num, 2);
    @(posedge clk); #1 scan = 1'b1;
    repeat (2) @(negedge clk);
    check("middrain_rise_clr", out_num, 0);

    // Reset during SEND word 1
    drive_rec(mk(64'hc0, 64'hc1, 64'hc2, 64'hc3), 1'b1, 1'b1);
    idle_in();
    wait_word(64'hc1, 20, "rstmid");
    #1 rst = 1'b1;
    sb.delete();
    #1;
    check("rstmid_valid", dout_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_data", dout_data, 0);
    check("rstmid_last", dout_last, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (dout_valid || busy) seen = 1'b1;
    end
    check("rstmid_quiet", seen, 0);
    drive_rec(mk(64'hd0, 64'hd1, 64'hd2, 64'hd3), 1'b1, 1'b1);
    idle_in();
    wait_idle(20, "rstmid_next");
    check("rstmid_out_num", out_num, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
